// File: rtl/axi_lite_mem_arbiter.sv
// Two-requester AXI4-Lite arbiter in front of a single memory port.
// Read and write paths arbitrate independently (round-robin, no preemption, one outstanding each).
module axi_lite_mem_arbiter #(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  resetn,

  input  logic [ADDR_WIDTH-1:0] m0_araddr,
  input  logic                  m0_arvalid,
  output logic                  m0_arready,
  output logic [31:0]           m0_rdata,
  output logic [1:0]            m0_rresp,
  output logic                  m0_rvalid,
  input  logic                  m0_rready,
  input  logic [ADDR_WIDTH-1:0] m0_awaddr,
  input  logic                  m0_awvalid,
  output logic                  m0_awready,
  input  logic [31:0]           m0_wdata,
  input  logic [3:0]            m0_wstrb,
  input  logic                  m0_wvalid,
  output logic                  m0_wready,
  output logic [1:0]            m0_bresp,
  output logic                  m0_bvalid,
  input  logic                  m0_bready,

  input  logic [ADDR_WIDTH-1:0] m1_araddr,
  input  logic                  m1_arvalid,
  output logic                  m1_arready,
  output logic [31:0]           m1_rdata,
  output logic [1:0]            m1_rresp,
  output logic                  m1_rvalid,
  input  logic                  m1_rready,
  input  logic [ADDR_WIDTH-1:0] m1_awaddr,
  input  logic                  m1_awvalid,
  output logic                  m1_awready,
  input  logic [31:0]           m1_wdata,
  input  logic [3:0]            m1_wstrb,
  input  logic                  m1_wvalid,
  output logic                  m1_wready,
  output logic [1:0]            m1_bresp,
  output logic                  m1_bvalid,
  input  logic                  m1_bready,

  output logic [ADDR_WIDTH-1:0] s_araddr,
  output logic                  s_arvalid,
  input  logic                  s_arready,
  input  logic [31:0]           s_rdata,
  input  logic [1:0]            s_rresp,
  input  logic                  s_rvalid,
  output logic                  s_rready,
  output logic [ADDR_WIDTH-1:0] s_awaddr,
  output logic                  s_awvalid,
  input  logic                  s_awready,
  output logic [31:0]           s_wdata,
  output logic [3:0]            s_wstrb,
  output logic                  s_wvalid,
  input  logic                  s_wready,
  input  logic [1:0]            s_bresp,
  input  logic                  s_bvalid,
  output logic                  s_bready,

  output logic [1:0]            rd_owner_o,
  output logic [1:0]            wr_owner_o,
  output logic                  busy_o
);

  // state | meaning
  // IDLE  | no owner, arbitrate among valid requesters
  // GRANT | owner's channels muxed onto s_*, held until the R / B handshake
  typedef enum logic {IDLE, GRANT} state_e;

  state_e     rd_state_q;
  logic [1:0] rd_owner_q;
  logic       rd_last_q;
  logic       ar_done_q;
  logic [1:0] rd_req;
  logic       rd_win1_d;

  state_e     wr_state_q;
  logic [1:0] wr_owner_q;
  logic       wr_last_q;
  logic       aw_done_q;
  logic       w_done_q;
  logic [1:0] wr_req;
  logic       wr_win1_d;

  // On a tie, requester 1 wins only if requester 0 won last time.
  assign rd_req    = {m1_arvalid, m0_arvalid};
  assign rd_win1_d = rd_req[1] & (~rd_req[0] | ~rd_last_q);
  assign wr_req    = {m1_awvalid | m1_wvalid, m0_awvalid | m0_wvalid};
  assign wr_win1_d = wr_req[1] & (~wr_req[0] | ~wr_last_q);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      rd_state_q <= IDLE;
      rd_owner_q <= 2'b00;
      rd_last_q  <= 1'b1;
      ar_done_q  <= 1'b0;
    end else begin
      case (rd_state_q)
        IDLE: begin
          if (|rd_req) begin
            rd_owner_q <= rd_win1_d ? 2'b10 : 2'b01;
            ar_done_q  <= 1'b0;
            rd_state_q <= GRANT;
          end
        end
        GRANT: begin
          if (s_arvalid && s_arready) ar_done_q <= 1'b1;
          if (s_rvalid && s_rready) begin
            rd_last_q  <= rd_owner_q[1];
            rd_owner_q <= 2'b00;
            ar_done_q  <= 1'b0;
            rd_state_q <= IDLE;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_state_q <= IDLE;
      wr_owner_q <= 2'b00;
      wr_last_q  <= 1'b1;
      aw_done_q  <= 1'b0;
      w_done_q   <= 1'b0;
    end else begin
      case (wr_state_q)
        IDLE: begin
          if (|wr_req) begin
            wr_owner_q <= wr_win1_d ? 2'b10 : 2'b01;
            aw_done_q  <= 1'b0;
            w_done_q   <= 1'b0;
            wr_state_q <= GRANT;
          end
        end
        GRANT: begin
          if (s_awvalid && s_awready) aw_done_q <= 1'b1;
          if (s_wvalid && s_wready) w_done_q <= 1'b1;
          if (s_bvalid && s_bready) begin
            wr_last_q  <= wr_owner_q[1];
            wr_owner_q <= 2'b00;
            aw_done_q  <= 1'b0;
            w_done_q   <= 1'b0;
            wr_state_q <= IDLE;
          end
        end
      endcase
    end
  end

  // Address/valid of a channel already handshaken is masked so a requester
  // holding valid for its next access cannot open a second outstanding one.
  assign s_araddr   = rd_owner_q[1] ? m1_araddr : m0_araddr;
  assign s_arvalid  = ~ar_done_q & ((rd_owner_q[0] & m0_arvalid) | (rd_owner_q[1] & m1_arvalid));
  assign s_rready   = (rd_owner_q[0] & m0_rready) | (rd_owner_q[1] & m1_rready);
  assign m0_arready = rd_owner_q[0] & ~ar_done_q & s_arready;
  assign m1_arready = rd_owner_q[1] & ~ar_done_q & s_arready;
  assign m0_rvalid  = rd_owner_q[0] & s_rvalid;
  assign m1_rvalid  = rd_owner_q[1] & s_rvalid;
  assign m0_rdata   = s_rdata;
  assign m1_rdata   = s_rdata;
  assign m0_rresp   = s_rresp;
  assign m1_rresp   = s_rresp;

  assign s_awaddr   = wr_owner_q[1] ? m1_awaddr : m0_awaddr;
  assign s_awvalid  = ~aw_done_q & ((wr_owner_q[0] & m0_awvalid) | (wr_owner_q[1] & m1_awvalid));
  assign s_wdata    = wr_owner_q[1] ? m1_wdata : m0_wdata;
  assign s_wstrb    = wr_owner_q[1] ? m1_wstrb : m0_wstrb;
  assign s_wvalid   = ~w_done_q & ((wr_owner_q[0] & m0_wvalid) | (wr_owner_q[1] & m1_wvalid));
  assign s_bready   = (wr_owner_q[0] & m0_bready) | (wr_owner_q[1] & m1_bready);
  assign m0_awready = wr_owner_q[0] & ~aw_done_q & s_awready;
  assign m1_awready = wr_owner_q[1] & ~aw_done_q & s_awready;
  assign m0_wready  = wr_owner_q[0] & ~w_done_q & s_wready;
  assign m1_wready  = wr_owner_q[1] & ~w_done_q & s_wready;
  assign m0_bvalid  = wr_owner_q[0] & s_bvalid;
  assign m1_bvalid  = wr_owner_q[1] & s_bvalid;
  assign m0_bresp   = s_bresp;
  assign m1_bresp   = s_bresp;

  assign rd_owner_o = rd_owner_q;
  assign wr_owner_o = wr_owner_q;
  assign busy_o     = |{rd_owner_q, wr_owner_q};

endmodule

// File: tb/tb_axi_lite_mem_arbiter.sv
// Bench for axi_lite_mem_arbiter: vector table plus hand sequences, with
// a behavioural memory slave and scoreboard queues for read and write traffic.
module tb_axi_lite_mem_arbiter;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] ara[2], awa[2], wd[2];
  logic [3:0]  ws[2];
  logic        arv[2], awv[2], wv[2];
  logic        rrdy[2], brdy[2];

  logic        m0_arready, m1_arready, m0_rvalid, m1_rvalid;
  logic [31:0] m0_rdata, m1_rdata;
  logic [1:0]  m0_rresp, m1_rresp, m0_bresp, m1_bresp;
  logic        m0_awready, m1_awready, m0_wready, m1_wready, m0_bvalid, m1_bvalid;
  logic [31:0] s_araddr, s_awaddr, s_wdata, s_rdata;
  logic [3:0]  s_wstrb;
  logic        s_arvalid, s_arready, s_rvalid, s_rready;
  logic        s_awvalid, s_awready, s_wvalid, s_wready, s_bvalid, s_bready;
  logic [1:0]  s_rresp, s_bresp;
  logic [1:0]  rd_owner_o, wr_owner_o;
  logic        busy_o;

  axi_lite_mem_arbiter #(.ADDR_WIDTH(32)) dut (
    .clk(clk), .resetn(resetn),
    .m0_araddr(ara[0]), .m0_arvalid(arv[0]), .m0_arready(m0_arready),
    .m0_rdata(m0_rdata), .m0_rresp(m0_rresp), .m0_rvalid(m0_rvalid), .m0_rready(rrdy[0]),
    .m0_awaddr(awa[0]), .m0_awvalid(awv[0]), .m0_awready(m0_awready),
    .m0_wdata(wd[0]), .m0_wstrb(ws[0]), .m0_wvalid(wv[0]), .m0_wready(m0_wready),
    .m0_bresp(m0_bresp), .m0_bvalid(m0_bvalid), .m0_bready(brdy[0]),
    .m1_araddr(ara[1]), .m1_arvalid(arv[1]), .m1_arready(m1_arready),
    .m1_rdata(m1_rdata), .m1_rresp(m1_rresp), .m1_rvalid(m1_rvalid), .m1_rready(rrdy[1]),
    .m1_awaddr(awa[1]), .m1_awvalid(awv[1]), .m1_awready(m1_awready),
    .m1_wdata(wd[1]), .m1_wstrb(ws[1]), .m1_wvalid(wv[1]), .m1_wready(m1_wready),
    .m1_bresp(m1_bresp), .m1_bvalid(m1_bvalid), .m1_bready(brdy[1]),
    .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
    .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
    .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
    .rd_owner_o(rd_owner_o), .wr_owner_o(wr_owner_o), .busy_o(busy_o)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_rd(logic [31:0] a);
    return (a == 32'h100) ? 32'hDEADBEEF : ~a;
  endfunction

  function automatic logic [31:0] oh(int id);
    return (id == 0) ? 32'd1 : 32'd2;
  endfunction

  // ---------------- memory slave model ----------------
  logic        slv_clr, slv_r_hold;
  logic [1:0]  slv_rresp, slv_bresp;
  int          slv_bdelay;
  logic        rd_pend, aw_got, w_got, b_pend;
  logic [31:0] rd_addr;
  int          b_cnt;

  assign s_arready = ~rd_pend;
  assign s_rvalid  = rd_pend & ~slv_r_hold;
  assign s_rdata   = mem_rd(rd_addr);
  assign s_rresp   = slv_rresp;
  assign s_awready = ~aw_got & ~b_pend;
  assign s_wready  = ~w_got & ~b_pend;
  assign s_bvalid  = b_pend;
  assign s_bresp   = slv_bresp;

  always @(posedge clk) begin
    if (slv_clr) begin
      rd_pend <= 1'b0; aw_got <= 1'b0; w_got <= 1'b0; b_pend <= 1'b0;
      rd_addr <= 32'h0; b_cnt <= 0;
    end else begin
      if (s_arvalid && s_arready) begin rd_pend <= 1'b1; rd_addr <= s_araddr; end
      if (s_rvalid && s_rready) rd_pend <= 1'b0;
      if (s_awvalid && s_awready) aw_got <= 1'b1;
      if (s_wvalid && s_wready) w_got <= 1'b1;
      if (aw_got && w_got) begin
        if (b_cnt >= slv_bdelay) begin
          b_pend <= 1'b1; aw_got <= 1'b0; w_got <= 1'b0; b_cnt <= 0;
        end else b_cnt <= b_cnt + 1;
      end
      if (s_bvalid && s_bready) b_pend <= 1'b0;
    end
  end

  // ---------------- scoreboard ----------------
  typedef struct {
    int          id;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [1:0]  resp;
  } exp_t;
  exp_t rd_q[$];
  exp_t wr_q[$];
  logic [1:0] wr_grants[$];
  logic [1:0] prev_wr = 2'b00;

  task automatic rd_rsp(int id, logic [31:0] d, logic [1:0] r);
    exp_t e;
    chk("rd_rsp_expected", 32'(rd_q.size() != 0), 32'd1);
    if (rd_q.size() != 0) begin
      e = rd_q.pop_front();
      chk("rd_rsp_requester", id, e.id);
      chk("rdata", d, e.data);
      chk("rresp", 32'(r), 32'(e.resp));
    end
  endtask

  task automatic wr_rsp(int id, logic [1:0] r);
    exp_t e;
    chk("wr_rsp_expected", 32'(wr_q.size() != 0), 32'd1);
    if (wr_q.size() != 0) begin
      e = wr_q.pop_front();
      chk("wr_rsp_requester", id, e.id);
      chk("bresp", 32'(r), 32'(e.resp));
    end
  endtask

  always @(negedge clk) begin
    if (resetn) begin
      if (s_arvalid && s_arready) begin
        chk("ar_expected", 32'(rd_q.size() != 0), 32'd1);
        if (rd_q.size() != 0) begin
          chk("s_araddr", s_araddr, rd_q[0].addr);
          chk("rd_owner_at_ar", 32'(rd_owner_o), oh(rd_q[0].id));
        end
      end
      if (s_awvalid && s_awready) begin
        chk("aw_expected", 32'(wr_q.size() != 0), 32'd1);
        if (wr_q.size() != 0) begin
          chk("s_awaddr", s_awaddr, wr_q[0].addr);
          chk("wr_owner_at_aw", 32'(wr_owner_o), oh(wr_q[0].id));
        end
      end
      if (s_wvalid && s_wready) begin
        chk("w_expected", 32'(wr_q.size() != 0), 32'd1);
        if (wr_q.size() != 0) begin
          chk("s_wdata", s_wdata, wr_q[0].data);
          chk("s_wstrb", 32'(s_wstrb), 32'(wr_q[0].strb));
        end
      end
      if (m0_rvalid && rrdy[0]) rd_rsp(0, m0_rdata, m0_rresp);
      if (m1_rvalid && rrdy[1]) rd_rsp(1, m1_rdata, m1_rresp);
      if (m0_bvalid && brdy[0]) wr_rsp(0, m0_bresp);
      if (m1_bvalid && brdy[1]) wr_rsp(1, m1_bresp);
      chk("nonowner_leak", 32'({m0_arready & ~rd_owner_o[0], m1_arready & ~rd_owner_o[1],
                                 m0_rvalid & ~rd_owner_o[0], m1_rvalid & ~rd_owner_o[1],
                                 m0_awready & ~wr_owner_o[0], m1_awready & ~wr_owner_o[1],
                                 m0_wready & ~wr_owner_o[0], m1_wready & ~wr_owner_o[1],
                                 m0_bvalid & ~wr_owner_o[0], m1_bvalid & ~wr_owner_o[1]}), 32'd0);
    end
    if (prev_wr == 2'b00 && wr_owner_o != 2'b00) wr_grants.push_back(wr_owner_o);
    prev_wr <= wr_owner_o;
  end

  // ---------------- requester tasks ----------------
  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic rd_txn(int id, logic [31:0] addr);
    logic hs;
    int n;
    arv[id] = 1'b1; ara[id] = addr;
    hs = 1'b0; n = 0;
    while (!hs && n < 60) begin
      @(negedge clk);
      hs = (id == 0) ? m0_arready : m1_arready;
      step(); n++;
    end
    arv[id] = 1'b0;
    chk("rd_ar_handshake", 32'(hs), 32'd1);
    hs = 1'b0; n = 0;
    while (!hs && n < 60) begin
      @(negedge clk);
      hs = (id == 0) ? m0_rvalid : m1_rvalid;
      step(); n++;
    end
    chk("rd_r_handshake", 32'(hs), 32'd1);
  endtask

  task automatic wr_txn(int id, logic [31:0] addr, logic [31:0] data, logic [3:0] strb, int w_lead);
    logic aw_ok, w_ok, awh, wh, hs;
    int n;
    awa[id] = addr; wd[id] = data; ws[id] = strb;
    wv[id] = 1'b1; awv[id] = (w_lead == 0);
    aw_ok = 1'b0; w_ok = 1'b0; n = 0;
    while (!(aw_ok && w_ok) && n < 60) begin
      @(negedge clk);
      awh = awv[id] & ((id == 0) ? m0_awready : m1_awready);
      wh  = wv[id] & ((id == 0) ? m0_wready : m1_wready);
      step(); n++;
      if (awh) begin awv[id] = 1'b0; aw_ok = 1'b1; end
      if (wh) begin wv[id] = 1'b0; w_ok = 1'b1; end
      if (!aw_ok && n == w_lead) awv[id] = 1'b1;
    end
    awv[id] = 1'b0; wv[id] = 1'b0;
    chk("wr_aw_w_handshake", 32'(aw_ok & w_ok), 32'd1);
    hs = 1'b0; n = 0;
    while (!hs && n < 60) begin
      @(negedge clk);
      hs = (id == 0) ? m0_bvalid : m1_bvalid;
      step(); n++;
    end
    chk("wr_b_handshake", 32'(hs), 32'd1);
  endtask

  function automatic exp_t mk(int id, logic [31:0] a, logic [31:0] d, logic [3:0] s, logic [1:0] r);
    exp_t e;
    e.id = id; e.addr = a; e.data = d; e.strb = s; e.resp = r;
    return e;
  endfunction

  typedef struct {
    bit          wr;
    int          id;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [1:0]  resp;
    int          bdelay;
    logic [31:0] exp_rdata;
  } vec_t;
  vec_t vecs[7];

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    vecs[0] = '{1'b0, 0, 32'h0000_0100, 32'h0, 4'h0, 2'b00, 0, 32'hDEADBEEF};
    vecs[1] = '{1'b0, 1, 32'h0000_0104, 32'h0, 4'h0, 2'b10, 0, 32'hFFFF_FEFB};
    vecs[2] = '{1'b0, 0, 32'h0000_0000, 32'h0, 4'h0, 2'b11, 0, 32'hFFFF_FFFF};
    vecs[3] = '{1'b1, 0, 32'h0000_0200, 32'h1234_5678, 4'hF, 2'b00, 0, 32'h0};
    vecs[4] = '{1'b1, 1, 32'h0000_0204, 32'hCAFE_F00D, 4'h3, 2'b10, 2, 32'h0};
    vecs[5] = '{1'b1, 1, 32'hFFFF_FFFC, 32'hA5A5_5A5A, 4'h8, 2'b11, 0, 32'h0};
    vecs[6] = '{1'b0, 1, 32'hFFFF_FFFC, 32'h0, 4'h0, 2'b01, 0, 32'h0000_0003};

    for (int i = 0; i < 2; i++) begin
      ara[i] = '0; awa[i] = '0; wd[i] = '0; ws[i] = '0;
      arv[i] = 1'b0; awv[i] = 1'b0; wv[i] = 1'b0; rrdy[i] = 1'b1; brdy[i] = 1'b1;
    end
    slv_clr = 1'b1; slv_r_hold = 1'b0; slv_rresp = 2'b00; slv_bresp = 2'b00; slv_bdelay = 0;
    ara[0] = 32'h0000_0ABC; awa[0] = 32'h0000_0DEF;
    ara[1] = 32'h0000_1111; awa[1] = 32'h0000_2222;
    arv[0] = 1'b1; wv[1] = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_rd_owner", 32'(rd_owner_o), 32'd0);
    chk("rst_wr_owner", 32'(wr_owner_o), 32'd0);
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_m_ready_valid", 32'({m0_arready, m1_arready, m0_rvalid, m1_rvalid, m0_awready, m1_awready,
                                   m0_wready, m1_wready, m0_bvalid, m1_bvalid}), 32'd0);
    chk("rst_s_valid_ready", 32'({s_arvalid, s_rready, s_awvalid, s_wvalid, s_bready}), 32'd0);
    chk("rst_s_araddr_from_m0", s_araddr, 32'h0000_0ABC);
    chk("rst_s_awaddr_from_m0", s_awaddr, 32'h0000_0DEF);
    step();
    arv[0] = 1'b0; wv[1] = 1'b0;
    resetn = 1'b1; slv_clr = 1'b0;
    step();

    // simultaneous reads right after reset: 0 first, one idle cycle, then 1
    rd_q.push_back(mk(0, 32'h400, mem_rd(32'h400), 4'h0, 2'b00));
    rd_q.push_back(mk(1, 32'h500, mem_rd(32'h500), 4'h0, 2'b00));
    fork
      rd_txn(0, 32'h400);
      rd_txn(1, 32'h500);
      begin
        n = 0;
        do begin @(negedge clk); n++; end while (rd_owner_o != 2'b01 && n < 20);
        chk("sim_first_grant", 32'(rd_owner_o), 32'd1);
        n = 0;
        do begin @(negedge clk); n++; end while (rd_owner_o == 2'b01 && n < 20);
        chk("sim_idle_gap", 32'(rd_owner_o), 32'd0);
        @(negedge clk);
        chk("sim_second_grant", 32'(rd_owner_o), 32'd2);
      end
    join

    // single read cycle-accurate owner timing
    rd_q.push_back(mk(0, 32'h100, 32'hDEADBEEF, 4'h0, 2'b00));
    fork
      rd_txn(0, 32'h100);
      begin
        @(negedge clk); chk("single_T_owner", 32'(rd_owner_o), 32'd0);
        @(negedge clk); chk("single_T1_owner", 32'(rd_owner_o), 32'd1);
        chk("single_T1_arvalid", 32'(s_arvalid), 32'd1);
        @(negedge clk); chk("single_T2_owner", 32'(rd_owner_o), 32'd1);
        chk("single_T2_rdata", m0_rdata, 32'hDEADBEEF);
        @(negedge clk); chk("single_T3_owner", 32'(rd_owner_o), 32'd0);
      end
    join
    step();

    for (int i = 0; i < 7; i++) begin
      slv_rresp = vecs[i].resp; slv_bresp = vecs[i].resp; slv_bdelay = vecs[i].bdelay;
      if (vecs[i].wr) begin
        wr_q.push_back(mk(vecs[i].id, vecs[i].addr, vecs[i].wdata, vecs[i].strb, vecs[i].resp));
        wr_txn(vecs[i].id, vecs[i].addr, vecs[i].wdata, vecs[i].strb, 0);
      end else begin
        rd_q.push_back(mk(vecs[i].id, vecs[i].addr, vecs[i].exp_rdata, 4'h0, vecs[i].resp));
        rd_txn(vecs[i].id, vecs[i].addr);
      end
      @(negedge clk);
      chk("vec_idle_after", 32'({rd_owner_o, wr_owner_o, busy_o}), 32'd0);
      step();
    end

    // continuous write contention, bresp SLVERR
    slv_bresp = 2'b10; slv_bdelay = 0; slv_rresp = 2'b00;
    for (int i = 0; i < 4; i++) begin
      wr_q.push_back(mk(0, 32'h1000 + 32'(i * 4), 32'h0A00_0000 + 32'(i), 4'hF, 2'b10));
      wr_q.push_back(mk(1, 32'h2000 + 32'(i * 4), 32'h0B00_0000 + 32'(i), 4'h5, 2'b10));
    end
    wr_grants.delete();
    fork
      for (int i = 0; i < 4; i++) wr_txn(0, 32'h1000 + 32'(i * 4), 32'h0A00_0000 + 32'(i), 4'hF, 0);
      for (int j = 0; j < 4; j++) wr_txn(1, 32'h2000 + 32'(j * 4), 32'h0B00_0000 + 32'(j), 4'h5, 0);
    join
    chk("contention_grant_count", wr_grants.size(), 32'd8);
    for (int i = 0; i < 8 && i < wr_grants.size(); i++)
      chk("contention_grant_seq", 32'(wr_grants[i]), (i % 2 == 0) ? 32'd1 : 32'd2);
    step();

    // concurrent paths: write by 0 with stalled B, read by 1
    slv_bresp = 2'b00; slv_bdelay = 5;
    wr_q.push_back(mk(0, 32'h200, 32'h5555_AAAA, 4'hF, 2'b00));
    rd_q.push_back(mk(1, 32'h300, 32'hFFFF_FCFF, 4'h0, 2'b00));
    fork
      wr_txn(0, 32'h200, 32'h5555_AAAA, 4'hF, 0);
      begin
        rd_txn(1, 32'h300);
        @(negedge clk);
        chk("conc_wr_still_owned", 32'(wr_owner_o), 32'd1);
        chk("conc_rd_released", 32'(rd_owner_o), 32'd0);
        chk("conc_busy_during_stall", 32'(busy_o), 32'd1);
      end
    join
    @(negedge clk);
    chk("conc_busy_after_b", 32'(busy_o), 32'd0);
    step();

    // W before AW on requester 1
    slv_bdelay = 0;
    wr_q.push_back(mk(1, 32'h240, 32'h0F0F_1234, 4'hC, 2'b00));
    fork
      wr_txn(1, 32'h240, 32'h0F0F_1234, 4'hC, 3);
      begin
        @(negedge clk); chk("wfirst_T_owner", 32'(wr_owner_o), 32'd0);
        @(negedge clk); chk("wfirst_T1_owner", 32'(wr_owner_o), 32'd2);
        chk("wfirst_s_wvalid", 32'(s_wvalid), 32'd1);
        chk("wfirst_s_awvalid", 32'(s_awvalid), 32'd0);
      end
    join
    step();

    // read by 0 so the read pointer favours requester 1 before the reset
    rd_q.push_back(mk(0, 32'h500, mem_rd(32'h500), 4'h0, 2'b00));
    rd_txn(0, 32'h500);
    step();

    // reset while the read grant is held with R pending
    slv_r_hold = 1'b1;
    rd_q.push_back(mk(0, 32'h600, mem_rd(32'h600), 4'h0, 2'b00));
    arv[0] = 1'b1; ara[0] = 32'h600;
    n = 0;
    do begin @(negedge clk); n++; end while (!m0_arready && n < 20);
    chk("rst_mid_ar_hs", 32'(m0_arready), 32'd1);
    step();
    arv[0] = 1'b0;
    @(negedge clk);
    chk("rst_mid_held_owner", 32'(rd_owner_o), 32'd1);
    step();
    resetn = 1'b0;
    step();
    resetn = 1'b1; slv_r_hold = 1'b0;
    @(negedge clk);
    chk("rst_mid_owners", 32'({rd_owner_o, wr_owner_o, busy_o}), 32'd0);
    chk("rst_mid_m_signals", 32'({m0_arready, m1_arready, m0_rvalid, m1_rvalid, m0_awready, m1_awready,
                                   m0_wready, m1_wready, m0_bvalid, m1_bvalid}), 32'd0);
    chk("rst_mid_s_signals", 32'({s_arvalid, s_rready, s_awvalid, s_wvalid, s_bready}), 32'd0);
    rd_q.delete();
    step();
    slv_clr = 1'b1;
    step();
    slv_clr = 1'b0;

    rd_q.push_back(mk(0, 32'h700, mem_rd(32'h700), 4'h0, 2'b00));
    rd_q.push_back(mk(1, 32'h704, mem_rd(32'h704), 4'h0, 2'b00));
    fork
      rd_txn(0, 32'h700);
      rd_txn(1, 32'h704);
    join
    @(negedge clk);
    chk("final_rd_q_empty", rd_q.size(), 32'd0);
    chk("final_wr_q_empty", wr_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/axi_lite_mem_arbiter.md
# axi_lite_mem_arbiter

Two-requester arbiter sharing the controller's single AXI4-Lite memory master port. Requester 0 is the DMA engine; requester 1 is the descriptor/command fetch path (or any second master). Read (AR/R) and write (AW/W/B) paths are arbitrated independently with round-robin fairness. Each path allows at most one outstanding transaction.

## Interface
- ADDR_WIDTH, 32, address width of all AR/AW channels.
- clk  input  1  clock.
- resetn  input  1  reset, synchronous, active-low.
- mN_araddr (N=0,1)  input  ADDR_WIDTH  requester read address.
- mN_arvalid  input  1  / mN_arready  output  1  requester AR handshake.
- mN_rdata  output  32  / mN_rresp  output  2  / mN_rvalid  output  1  / mN_rready  input  1  requester R channel.
- mN_awaddr  input  ADDR_WIDTH  / mN_awvalid  input  1  / mN_awready  output  1  requester AW channel.
- mN_wdata  input  32  / mN_wstrb  input  4  / mN_wvalid  input  1  / mN_wready  output  1  requester W channel.
- mN_bresp  output  2  / mN_bvalid  output  1  / mN_bready  input  1  requester B channel.
- s_araddr, s_arvalid, s_arready, s_rdata, s_rresp, s_rvalid, s_rready: memory-side AR/R. Widths match the requester ports; directions are mirrored.
- s_awaddr, s_awvalid, s_awready, s_wdata, s_wstrb, s_wvalid, s_wready, s_bresp, s_bvalid, s_bready: memory-side AW/W/B. Widths match the requester ports; directions are mirrored.
- rd_owner_o  output  2  one-hot current read grant (00 = none).
- wr_owner_o  output  2  one-hot current write grant (00 = none).
- busy_o  output  1  OR of both grants.

## Operation
- Each path has its own FSM with states IDLE → GRANT → IDLE, plus a registered last-winner pointer `last`. The pointer resets to 1, so requester 0 wins the first tie.
- Read request: mN_arvalid.
- Write request: mN_awvalid | mN_wvalid. A requester may present W before AW.
- IDLE:
  - Sole requester: grant it.
  - Both requesting: grant requester !last.
  - Record the winner in the owner register and go to GRANT.
- GRANT, read path: the owner's AR and R channels are connected to s_* by a combinational mux.
  - Non-owner arready = 0 and rvalid = 0.
  - rdata/rresp are routed to both requesters; only the owner sees rvalid.
- GRANT, write path: the owner's AW, W and B channels are connected likewise.
  - Non-owner awready = 0, wready = 0, bvalid = 0.
- Transaction completion:
  - Read: s_rvalid & s_rready. Write: s_bvalid & s_bready.
  - On completion: owner ← 00, last ← winner, FSM → IDLE.
- A requester's valid is never forwarded while it is not the owner. s_* valids are 0 in IDLE.
- Arbitration never preempts. A requester that drops valid before its handshake completes (protocol violation) is not detected; the grant is held until completion.
- Responses (rresp/bresp, including SLVERR/DECERR) pass through unmodified. The arbiter keeps no error state.
- Read and write paths are fully independent: requester 0 may own the write path while requester 1 owns the read path.

## Timing
- Reset values:
  - rd_owner_o = wr_owner_o = 00, busy_o = 0, last = 1.
  - All mN_*ready/valid outputs = 0. All s_*valid/ready outputs = 0.
  - Data/resp outputs: don't-care, but s_araddr and s_awaddr are driven from requester 0 while idle.
- Arbitration latency: a request seen in IDLE in cycle T makes its owner bit and s_*valid high in cycle T+1. Channel handshakes can complete in T+1 at the earliest.
- Back-to-back transactions: completion at cycle C returns the FSM to IDLE at C+1. A pending request is granted at C+2. The minimum gap is one idle cycle per path.
- Alternation: with both requesters continuously valid, grants alternate 0, 1, 0, 1.
- Readiness passthrough: s_arready → mN_arready, s_wready → mN_wready, and so on, are purely combinational for the owner. There is no added handshake latency inside GRANT.
- Reset mid-transaction: grants clear on the next edge. Any slave response arriving afterwards is not forwarded.

## Test plan
- Single read by requester 0:
  - Stimulus: m0_arvalid=1, araddr=0x100; slave arready in T+1; rdata=0xDEADBEEF, rresp=00 in T+2.
  - Required: m0 receives 0xDEADBEEF; rd_owner_o is 01 in T+1..T+2 and 00 in T+3.
- Simultaneous reads from both requesters, issued right after reset:
  - Required: requester 0 is served first, then requester 1 after one idle cycle; m1_arready stays 0 until its grant.
- Continuous write contention, 4 writes each:
  - Required: wr_owner_o sequence is 01, 10, 01, 10, 01, 10, 01, 10.
  - Every s_awaddr/s_wdata matches the owner's values; bresp=10 from the slave is returned only to the owner.
- Concurrent paths:
  - Stimulus: requester 0 writes 0x200 while requester 1 reads 0x300, slave stalls B for 5 cycles.
  - Required: the read completes during the write stall; busy_o stays 1 until the B handshake.
- W-before-AW:
  - Stimulus: m1_wvalid asserted 3 cycles before m1_awvalid.
  - Required: write grant goes to requester 1 on wvalid; s_wvalid follows; the transaction completes correctly.
- Reset mid-transaction:
  - Stimulus: resetn=0 while the read grant is held and the R channel is pending.
  - Required: next cycle owners = 00 and all valids/readies = 0; the first post-reset contention grants requester 0.
